// File: rtl/id_ex_operand_if.sv
// id_ex_operand_if
// Bundle of the signals that enter and leave the ID->EX operand stage.
//   master : the side that drives the ID-stage instruction, the register-file
//            read data, the downstream writer info, ex_hold and flush; it
//            receives id_ready and the ID/EX pipeline register contents.
//   slave  : the id_ex_operand stage itself.
// Parameters: W  = datapath width, CW = stall counter width.
interface id_ex_operand_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    // ID-stage inputs
    logic          id_valid;
    logic [31:0]   id_instr;
    logic [W-1:0]  rf_rs;
    logic [W-1:0]  rf_rt;
    // writers further down the pipe
    logic          ex_wr;
    logic [4:0]    ex_rd;
    logic          exm_wr;
    logic [4:0]    exm_rd;
    logic          exm_load;
    logic [W-1:0]  exm_data;
    logic          mw_wr;
    logic [4:0]    mw_rd;
    logic [W-1:0]  mw_data;
    // pipeline control
    logic          ex_hold;
    logic          flush;
    // stage outputs
    logic          id_ready;
    logic [31:0]   instr_ex;
    logic [W-1:0]  A_ex;
    logic [W-1:0]  B_ex;
    logic [1:0]    Y_t_ex;
    logic          valid_ex;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_valid, id_instr, rf_rs, rf_rt,
        output ex_wr, ex_rd, exm_wr, exm_rd, exm_load, exm_data,
        output mw_wr, mw_rd, mw_data, ex_hold, flush,
        input  id_ready, instr_ex, A_ex, B_ex, Y_t_ex, valid_ex, stall_cnt
    );

    modport slave (
        input  id_valid, id_instr, rf_rs, rf_rt,
        input  ex_wr, ex_rd, exm_wr, exm_rd, exm_load, exm_data,
        input  mw_wr, mw_rd, mw_data, ex_hold, flush,
        output id_ready, instr_ex, A_ex, B_ex, Y_t_ex, valid_ex, stall_cnt
    );
endinterface

// File: rtl/id_ex_operand.sv
// id_ex_operand
// Decode-to-execute operand stage of a 5-stage MIPS pipeline. Decodes the
// ALU Y-operand select, resolves rs/rt through forwarding, detects RAW
// hazards (inserting bubbles) and registers the ID/EX pipeline register.
// Ports:
//   clk     : clock, all state updates on the rising edge
//   rst_n   : synchronous active-low reset
//   bus_io  : id_ex_operand_if.slave (ID inputs, writer info, hold/flush,
//             id_ready, instr_ex, A_ex, B_ex, Y_t_ex, valid_ex, stall_cnt)
// Build option: define FORWARD_EN to enable EX/MEM and MEM/WB forwarding;
// without it every pending write to a used source register stalls ID.
module id_ex_operand #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input logic              clk,
    input logic              rst_n,
    id_ex_operand_if.slave   bus_io
);

    logic [5:0]    opc;
    logic [5:0]    funct;
    logic [4:0]    rs_idx;
    logic [4:0]    rt_idx;
    logic          rt_used;
    logic [1:0]    ysel;
    logic [W:0]    rs_res;   // {hazard, value}
    logic [W:0]    rt_res;
    logic          hazard;

    logic [31:0]   instr_q, instr_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [1:0]    y_q, y_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] stall_q, stall_d;

    assign opc    = bus_io.id_instr[31:26];
    assign funct  = bus_io.id_instr[5:0];
    assign rs_idx = bus_io.id_instr[25:21];
    assign rt_idx = bus_io.id_instr[20:16];

    // R-type, beq, bne and sw read rt; every other format only reads rs.
    assign rt_used = (opc == 6'b000000) || (opc == 6'b000100) ||
                     (opc == 6'b000101) || (opc == 6'b101011);

    always_comb begin
        ysel = 2'd3;
        case (opc)
            6'b000000: ysel = (funct == 6'b000000 || funct == 6'b000010 ||
                               funct == 6'b000011) ? 2'd1 : 2'd0;
            6'b000001, 6'b000110, 6'b000111: ysel = 2'd2;
            6'b000100, 6'b000101, 6'b000010, 6'b000011: ysel = 2'd0;
            default: ysel = 2'd3;
        endcase
    end

    // Returns {hazard, operand} for one source register. $0 never depends
    // on anything and always reads the register file.
    function automatic logic [W:0] resolve(input logic [4:0] src,
                                           input logic [W-1:0] rf_val);
        resolve = {1'b0, rf_val};
        if (src != 5'd0) begin
`ifdef FORWARD_EN
            if (bus_io.ex_wr && bus_io.ex_rd == src)
                resolve = {1'b1, rf_val};
            else if (bus_io.exm_wr && bus_io.exm_rd == src)
                // a load's data is not available until after MEM
                resolve = bus_io.exm_load ? {1'b1, rf_val} : {1'b0, bus_io.exm_data};
            else if (bus_io.mw_wr && bus_io.mw_rd == src)
                resolve = {1'b0, bus_io.mw_data};
`else
            if ((bus_io.ex_wr  && bus_io.ex_rd  == src) ||
                (bus_io.exm_wr && bus_io.exm_rd == src) ||
                (bus_io.mw_wr  && bus_io.mw_rd  == src))
                resolve = {1'b1, rf_val};
`endif
        end
    endfunction

    assign rs_res = resolve(rs_idx, bus_io.rf_rs);
    assign rt_res = resolve(rt_idx, bus_io.rf_rt);

    assign hazard = bus_io.id_valid && (rs_res[W] || (rt_used && rt_res[W]));
    assign bus_io.id_ready = !hazard && !bus_io.ex_hold;

    always_comb begin
        instr_d = instr_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        valid_d = valid_q;
        stall_d = stall_q;
        // flush beats hold; a hazard only bubbles when the register may move
        if (bus_io.flush || (!bus_io.ex_hold && hazard)) begin
            instr_d = 32'd0;
            a_d     = '0;
            b_d     = '0;
            y_d     = 2'd0;
            valid_d = 1'b0;
        end else if (!bus_io.ex_hold) begin
            instr_d = bus_io.id_instr;
            a_d     = rs_res[W-1:0];
            b_d     = rt_res[W-1:0];
            y_d     = ysel;
            valid_d = bus_io.id_valid;
        end
        if (hazard && !bus_io.ex_hold && !bus_io.flush && stall_q != {CW{1'b1}})
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= 32'd0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= 2'd0;
            valid_q <= 1'b0;
            stall_q <= '0;
        end else begin
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign bus_io.instr_ex  = instr_q;
    assign bus_io.A_ex      = a_q;
    assign bus_io.B_ex      = b_q;
    assign bus_io.Y_t_ex    = y_q;
    assign bus_io.valid_ex  = valid_q;
    assign bus_io.stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_operand.sv
module tb_id_ex_operand;
    localparam int W  = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [31:0]  instr;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   y;
        logic         v;
    } exp_t;

    localparam logic [31:0] ORI_I  = 32'h3401_8000; // ori  $1,$0,0x8000
    localparam logic [31:0] SLL_I  = 32'h0001_1100; // sll  $2,$1,4
    localparam logic [31:0] ADD_I  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] BLEZ_I = 32'h1820_0003; // blez $1,3
    localparam logic [31:0] ADD5_I = 32'h0084_2820; // add  $5,$4,$4

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_operand_if #(.W(W), .CW(CW)) bus ();
    id_ex_operand #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    exp_t sb[$];
    exp_t got;
    exp_t exp_v;
    exp_t bubble;

    task automatic idle();
        bus.id_valid = 0; bus.id_instr = 0; bus.rf_rs = 0; bus.rf_rt = 0;
        bus.ex_wr = 0; bus.ex_rd = 0; bus.exm_wr = 0; bus.exm_rd = 0;
        bus.exm_load = 0; bus.exm_data = 0; bus.mw_wr = 0; bus.mw_rd = 0;
        bus.mw_data = 0; bus.ex_hold = 0; bus.flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.id_instr = ADD_I; bus.rf_rs = 32'hFFFF_FFFF;
        rst_n = 0;
        tick(); tick();
        got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", got); end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%h exp=0", bus.stall_cnt); end
        checks++;
        if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.id_ready); end
        rst_n = 1;
        exp_stall = 0;
    endtask

    task automatic test_decode();
        logic [31:0] tbl [4];
        logic [1:0]  ytb [4];
        tbl[0] = ORI_I; ytb[0] = 2'd3;
        tbl[1] = SLL_I; ytb[1] = 2'd1;
        tbl[2] = ADD_I; ytb[2] = 2'd0;
        tbl[3] = BLEZ_I; ytb[3] = 2'd2;
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.id_valid = 1; bus.id_instr = tbl[i];
            bus.rf_rs = $urandom; bus.rf_rt = $urandom;
            #1;
            checks++;
            if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL decode_ready[%0d] got=%b exp=1", i, bus.id_ready); end
            sb.push_back({tbl[i], bus.rf_rs, bus.rf_rt, ytb[i], 1'b1});
            tick();
            got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL decode[%0d] got=%h exp=%h", i, got, exp_v); end
        end
    endtask

    task automatic test_forward();
        idle();
        bus.id_valid = 1; bus.id_instr = ADD_I;
        bus.rf_rs = 32'h0000_AAAA; bus.rf_rt = 32'h0000_BBBB;
        bus.exm_wr = 1; bus.exm_rd = 5'd1; bus.exm_data = 32'h1234;
        bus.mw_wr = 1; bus.mw_rd = 5'd1; bus.mw_data = 32'h5678;
        #1;
`ifdef FORWARD_EN
        checks++;
        if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got=%b exp=1", bus.id_ready); end
        sb.push_back({ADD_I, 32'h1234, 32'h0000_BBBB, 2'd0, 1'b1});
`else
        checks++;
        if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL fwd_ready got=%b exp=0", bus.id_ready); end
        sb.push_back(bubble);
        exp_stall++;
`endif
        tick();
        got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL forward got=%h exp=%h", got, exp_v); end
        checks++;
        if (bus.stall_cnt !== exp_stall[CW-1:0]) begin errors++; $display("FAIL fwd_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
    endtask

    task automatic test_load_use();
        logic ready_exp;
        idle();
        bus.id_valid = 1; bus.id_instr = ADD5_I;
        bus.rf_rs = 32'h1111; bus.rf_rt = 32'h1111;
        for (int p = 0; p < 4; p++) begin
            bus.ex_wr = 0; bus.exm_wr = 0; bus.exm_load = 0; bus.mw_wr = 0;
            case (p)
                0: begin bus.ex_wr = 1; bus.ex_rd = 5'd4; end
                1: begin bus.exm_wr = 1; bus.exm_rd = 5'd4; bus.exm_load = 1; bus.exm_data = 32'hDEAD; end
                2: begin bus.mw_wr = 1; bus.mw_rd = 5'd4; bus.mw_data = 32'hCAFE_0004; end
                default: ;
            endcase
            ready_exp = 1'b0;
            if (p < 2) begin
                sb.push_back(bubble); exp_stall++;
            end else begin
`ifdef FORWARD_EN
                if (p == 3) break;
                ready_exp = 1'b1;
                sb.push_back({ADD5_I, 32'hCAFE_0004, 32'hCAFE_0004, 2'd0, 1'b1});
`else
                if (p == 2) begin
                    sb.push_back(bubble); exp_stall++;
                end else begin
                    ready_exp = 1'b1;
                    sb.push_back({ADD5_I, 32'h1111, 32'h1111, 2'd0, 1'b1});
                end
`endif
            end
            #1;
            checks++;
            if (bus.id_ready !== ready_exp) begin errors++; $display("FAIL lu_ready[%0d] got=%b exp=%b", p, bus.id_ready, ready_exp); end
            tick();
            got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL load_use[%0d] got=%h exp=%h", p, got, exp_v); end
        end
        checks++;
        if (bus.stall_cnt !== exp_stall[CW-1:0]) begin errors++; $display("FAIL lu_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
    endtask

    task automatic test_flush_hazard();
        idle();
        bus.id_valid = 1; bus.id_instr = ADD_I; bus.rf_rs = 32'h77; bus.rf_rt = 32'h88;
        bus.ex_wr = 1; bus.ex_rd = 5'd1; bus.flush = 1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", bus.id_ready); end
        sb.push_back(bubble);
        tick();
        got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL flush got=%h exp=%h", got, exp_v); end
        checks++;
        if (bus.stall_cnt !== exp_stall[CW-1:0]) begin errors++; $display("FAIL flush_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
    endtask

    task automatic test_hold();
        exp_t held;
        idle();
        bus.id_valid = 1; bus.id_instr = ORI_I; bus.rf_rs = 32'h5; bus.rf_rt = 32'h6;
        held = {ORI_I, 32'h5, 32'h6, 2'd3, 1'b1};
        sb.push_back(held);
        tick();
        got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL hold_load got=%h exp=%h", got, exp_v); end
        bus.ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_instr = SLL_I; bus.rf_rs = $urandom; bus.rf_rt = $urandom;
            bus.ex_wr = (i != 1); bus.ex_rd = 5'd1;
            #1;
            checks++;
            if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, bus.id_ready); end
            sb.push_back(held);
            tick();
            got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp_v); end
        end
        checks++;
        if (bus.stall_cnt !== exp_stall[CW-1:0]) begin errors++; $display("FAIL hold_stall got=%0d exp=%0d", bus.stall_cnt, exp_stall); end
        bus.ex_hold = 0;
    endtask

    task automatic test_saturate();
        int n;
        idle();
        bus.id_valid = 1; bus.id_instr = ADD_I; bus.ex_wr = 1; bus.ex_rd = 5'd2;
        n = 65535 - exp_stall + 4;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat got=%h exp=ffff", bus.stall_cnt); end
        tick();
        got = {bus.instr_ex, bus.A_ex, bus.B_ex, bus.Y_t_ex, bus.valid_ex};
        checks++;
        if (got !== bubble) begin errors++; $display("FAIL sat_bubble got=%h exp=%h", got, bubble); end
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", bus.stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 0;
        tick();
        checks++;
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_stall got=%h exp=0", bus.stall_cnt); end
        rst_n = 1;
        tick();
        checks++;
        if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL midrst_restart got=%h exp=1", bus.stall_cnt); end
    endtask

    initial begin
        bubble = '0;
        rst_n = 0;
        idle();
        test_reset();
        test_decode();
        test_forward();
        test_load_use();
        test_flush_hazard();
        test_hold();
        test_saturate();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
